// File: rtl/mem_sram_ctrl.sv
// Memory-stage SRAM controller: turns EXE/MEM load/store requests into fixed-wait-state
// accesses on a single-port 32-bit SRAM and stalls the pipeline while an access is in flight.
module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [31:0]       Val_Rm,
    output logic              freeze,
    output logic              ready,
    output logic [31:0]       read_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_out,
    input  logic [31:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                req;
    logic [ADDR_W-1:0]   word_addr;
    logic                access;

    assign req       = MEM_R_EN | MEM_W_EN;
    assign word_addr = ADDR_W'((ALU_Res - BASE_ADDR) >> 2);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    addr_d  = word_addr;
                    wdata_d = Val_Rm;
                    wr_d    = MEM_W_EN;  // both enables set means store
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode only registered state, so reset releases them immediately.
    assign access      = (state_q == ACCESS);
    assign sram_ce_n   = !access;
    assign sram_oe_n   = !(access && !wr_q);
    assign sram_we_n   = !(access && wr_q);
    assign sram_dq_oe  = access && wr_q;
    assign sram_dq_out = wdata_q;
    assign sram_addr   = addr_q;

    assign ready     = (state_q == DONE);
    assign freeze    = req && (state_q != DONE);
    assign read_data = rdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small behavioural SRAM model.
module tb_mem_sram_ctrl;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              MEM_R_EN = 1'b0;
    logic              MEM_W_EN = 1'b0;
    logic [31:0]       ALU_Res = 32'd0;
    logic [31:0]       Val_Rm = 32'd0;
    logic              freeze, ready;
    logic [31:0]       read_data;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dq_out, sram_dq_in;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_sram_ctrl #(.BASE_ADDR(32'd1024), .ADDR_W(ADDR_W), .WAIT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_Res    (ALU_Res),
        .Val_Rm     (Val_Rm),
        .freeze     (freeze),
        .ready      (ready),
        .read_data  (read_data),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    // SRAM model: 16 words, preload port for the bench.
    logic [31:0] mem [0:15];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem[sram_addr[3:0]] <= sram_dq_out;
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 32'd0;

    typedef struct {
        int          rdy;       // sample index where ready was seen (0 = never)
        int          fz;        // samples with freeze high
        int          we;        // samples with we_n low
        int          oe;        // samples with oe_n low
        logic        fz_first;
        logic        fz_done;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] dq;
        logic        dq_oe;
    } acc_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    // Presents a request at the next negedge and follows it until ready (bounded).
    task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, output acc_t r);
        bit seen_access = 0;
        r = '{rdy: 0, fz: 0, we: 0, oe: 0, fz_first: 1'b0, fz_done: 1'b1,
              rd: 32'd0, addr: 32'd0, dq: 32'd0, dq_oe: 1'b0};
        @(negedge clk);
        MEM_R_EN = re;
        MEM_W_EN = we;
        ALU_Res  = addr;
        Val_Rm   = data;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (i == 1) r.fz_first = freeze;
            if (freeze) r.fz++;
            if (!sram_we_n) r.we++;
            if (!sram_oe_n) r.oe++;
            if (!sram_ce_n && !seen_access) begin
                seen_access = 1;
                r.addr  = 32'(sram_addr);
                r.dq    = sram_dq_out;
                r.dq_oe = sram_dq_oe;
            end
            if (ready) begin
                r.rdy     = i;
                r.fz_done = freeze;
                r.rd      = read_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    acc_t r;
    acc_t r2;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_freeze", freeze, 0);
        check("rst_ready", ready, 0);
        check("rst_read_data", read_data, 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_dq_out", sram_dq_out, 0);
        rst_n = 1'b1;

        // No request for 10 cycles
        begin
            int fz_hi = 0, rdy_hi = 0, ce_lo = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                #1;
                if (freeze) fz_hi++;
                if (ready) rdy_hi++;
                if (!sram_ce_n) ce_lo++;
            end
            check("idle_freeze_cycles", fz_hi, 0);
            check("idle_ready_cycles", rdy_hi, 0);
            check("idle_ce_low_cycles", ce_lo, 0);
        end

        // Store 0xDEADBEEF to 1032 (word 2)
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, r);
        MEM_W_EN = 1'b0;
        check("st_ready_cycle", r.rdy, 6);
        check("st_freeze_cycles", r.fz, 5);
        check("st_we_low_cycles", r.we, 4);
        check("st_oe_low_cycles", r.oe, 0);
        check("st_addr", r.addr, 2);
        check("st_dq_oe", r.dq_oe, 1);
        check("st_dq_out", r.dq, 32'hDEADBEEF);
        check("st_read_data_kept", r.rd, 0);
        check("st_mem_word2", mem[2], 32'hDEADBEEF);

        // Load from 1032 with the model returning 0x12345678
        @(negedge clk);
        pre_en = 1'b1; pre_idx = 4'd2; pre_val = 32'h12345678;
        @(negedge clk);
        pre_en = 1'b0;
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, r);
        MEM_R_EN = 1'b0;
        check("ld_ready_cycle", r.rdy, 6);
        check("ld_oe_low_cycles", r.oe, 4);
        check("ld_we_low_cycles", r.we, 0);
        check("ld_dq_oe", r.dq_oe, 0);
        check("ld_read_data", r.rd, 32'h12345678);
        check("ld_freeze_in_done", r.fz_done, 0);

        // Back-to-back store then load at 1028, request never dropped
        @(negedge clk);
        do_access(1'b0, 1'b1, 32'd1028, 32'hA5A50F0F, r);
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, r2);
        MEM_R_EN = 1'b0;
        check("b2b_st_freeze_cycles", r.fz, 5);
        check("b2b_st_freeze_done", r.fz_done, 0);
        check("b2b_turnaround_freeze", r2.fz_first, 1);
        check("b2b_ld_ready_cycle", r2.rdy, 6);
        check("b2b_ld_freeze_cycles", r2.fz, 5);
        check("b2b_ld_addr", r2.addr, 1);
        check("b2b_ld_data", r2.rd, 32'hA5A50F0F);

        // Both enables: store wins, read_data unchanged
        do_access(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, r);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        check("both_we_low_cycles", r.we, 4);
        check("both_oe_low_cycles", r.oe, 0);
        check("both_read_data", r.rd, 32'hA5A50F0F);
        check("both_mem_word3", mem[3], 32'hCAFEF00D);

        // Reset asserted in the middle of a store
        @(negedge clk);
        @(negedge clk);
        MEM_W_EN = 1'b1; ALU_Res = 32'd1040; Val_Rm = 32'h11112222;
        repeat (2) @(negedge clk);
        #1;
        check("mid_we_low_before_rst", sram_we_n, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we_n", sram_we_n, 1);
        check("mid_rst_oe_n", sram_oe_n, 1);
        check("mid_rst_ce_n", sram_ce_n, 1);
        check("mid_rst_dq_oe", sram_dq_oe, 0);
        check("mid_rst_read_data", read_data, 0);
        MEM_W_EN = 1'b0;
        #1;
        check("mid_rst_freeze", freeze, 0);
        check("mid_rst_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
